spi_cmd_ctrl: RTL and testbench
===============================

// Module: spi_cmd_ctrl
//
// PURPOSE
//  System-clock command sequencer behind the SPI slave receiver/transmitter.
//  Consumes received bytes, parses framed commands (opcode, address, data) and
//  maintains an NREGS x 8-bit register file. Read commands stage a byte for the
//  SPI transmit path. Sits between the SPI slave and the user logic (LED/SD control).
//
// PARAMETERS
//  NREGS        8       number of 8-bit registers; range 2..256
//  TIMEOUT_CYC  50000   i_clk cycles without a byte before an open frame aborts
//                       (used only when SPI_CMD_TIMEOUT_EN is defined)
//
// PORTS
//  i_clk        in   1          system clock
//  i_sys_rst    in   1          synchronous reset, active-high
//  i_cs         in   1          raw SPI chip select, active-low, asynchronous to i_clk
//  i_rx_byte    in   8          received byte; valid while i_rx_valid is high
//  i_rx_valid   in   1          single-cycle strobe: one byte received
//  o_tx_byte    out  8          byte staged for the next SPI transmission
//  o_tx_rdy     out  1          single-cycle strobe: o_tx_byte is updated
//  o_regs       out  8*NREGS    flattened register file; reg[k] = o_regs[8k+7:8k]
//  o_wr_strobe  out  1          single-cycle pulse: a register was written
//  o_wr_addr    out  8          address of the last write
//  o_busy       out  1          high while a frame is open (state != IDLE)
//  o_err        out  1          sticky protocol-error flag
//
// BEHAVIOUR
//  - i_cs passes through a 2-flop synchroniser. cs_rise is the 0->1 edge of the
//    synchronised signal (the frame ends).
//  - Reset: state IDLE; all registers 0; o_tx_byte 8'h00; o_tx_rdy, o_wr_strobe,
//    o_busy, o_err all 0; o_wr_addr 0.
//  - Opcodes: 8'h00 NOP, 8'h01 WR, 8'h02 RD, 8'h0E CLR_ERR. Any other opcode is illegal.
//  - FSM (advances only on i_rx_valid, except for abort):
//    IDLE  : NOP -> IDLE. CLR_ERR -> clears o_err, IDLE. WR -> WADDR. RD -> RADDR.
//            Illegal opcode -> set o_err, go to ERR.
//    WADDR : byte < NREGS -> latch addr, go to WDATA. Otherwise set o_err, go to ERR.
//    WDATA : reg[addr] <= byte. o_wr_strobe=1 and o_wr_addr=addr on the next cycle.
//            Then IDLE (a new opcode may follow in the same CS frame).
//    RADDR : byte < NREGS -> o_tx_byte <= reg[addr], o_tx_rdy=1 for one cycle, then IDLE.
//            Otherwise o_tx_byte <= 8'hFF, o_tx_rdy pulse, set o_err, go to ERR.
//    ERR   : ignores all bytes until cs_rise, then IDLE.
//  - Latency: i_rx_valid in cycle N -> o_wr_strobe / o_tx_rdy / o_err valid in N+1.
//  - Address compare uses the full 8-bit byte against NREGS.
//    Stored index width is $clog2(NREGS).
//  - cs_rise from any state -> IDLE and the partial frame is discarded. No register
//    write occurs. o_err is unchanged.
//  - cs_rise and i_rx_valid in the same cycle: abort wins and the byte is dropped.
//  - i_rx_valid while o_tx_rdy is high: processed normally. Strobes never stretch.
//  - Reset asserted mid-frame: immediate return to the reset values above.
//  - o_err stays set until CLR_ERR or reset. If a new error occurs in the same
//    cycle as CLR_ERR, the flag is set.
//
// CONFIGURATION
//  SPI_CMD_TIMEOUT_EN defined:
//    - A counter clears on every i_rx_valid and on IDLE entry.
//    - In WADDR/WDATA/RADDR it counts; reaching TIMEOUT_CYC-1 -> IDLE and set o_err.
//    - ERR is not timed out.
//  Not defined: no counter. An open frame waits indefinitely for a byte or cs_rise.
//
// STRUCTURE
//  - spi_cmd_pkg.vh (shared include): opcode localparams, FSM state encoding,
//    TX_ERR_BYTE = 8'hFF.
//  - One sub-module: spi_cmd_regfile (NREGS x 8; write port addr/data/we;
//    combinational read port; flattened output; synchronous reset to 0).
//  - Synchroniser, FSM and timeout logic stay in spi_cmd_ctrl.
//
// TESTING
//  1. Reset, then idle -> all outputs 0, o_regs all 0, o_busy 0.
//  2. CS low, bytes 01,03,A5, CS high -> o_wr_strobe pulse one cycle after A5;
//     o_wr_addr=3; reg[3]=A5.
//  3. After test 2, bytes 02,03 -> o_tx_byte=A5 with one o_tx_rdy pulse;
//     o_err stays 0.
//  4. Bytes 7F,01,00,55 in one frame -> o_err=1; regs unchanged.
//     Then new frame with 0E -> o_err=0.
//  5. Bytes 01,02 then CS high -> IDLE, no write; a following frame 01,02,11 writes reg[2]=11.
//  6. Bytes 02,08 (NREGS=8) -> o_tx_byte=FF, o_tx_rdy pulse, o_err=1.
//     With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: byte 01 then 16 idle cycles
//     -> o_busy 0 and o_err 1.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_pkg
//  Description : Shared opcodes, FSM state encoding and constant bytes for
//                the SPI command sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_cmd_pkg;

    // Command opcodes (first byte of every command)
    localparam logic [7:0] c_op_nop     = 8'h00;
    localparam logic [7:0] c_op_wr      = 8'h01;
    localparam logic [7:0] c_op_rd      = 8'h02;
    localparam logic [7:0] c_op_clr_err = 8'h0E;

    // Byte returned to the SPI master for an out-of-range read
    localparam logic [7:0] c_tx_err_byte = 8'hFF;

    // Command parser states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WADDR = 3'd1,
        ST_WDATA = 3'd2,
        ST_RADDR = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_cmd_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_regfile
//  Description : NREGS x 8-bit register file with one synchronous write port,
//                one combinational read port and a flattened image output.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_regfile #(
    parameter int NREGS   = 8,
    parameter int ADDR_W  = 3
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_rst,
    input  wire logic                 i_we,
    input  wire logic [ADDR_W-1:0]    i_waddr,
    input  wire logic [7:0]           i_wdata,
    input  wire logic [ADDR_W-1:0]    i_raddr,
    output logic      [7:0]           o_rdata,
    output logic      [8*NREGS-1:0]   o_regs
);

    logic [7:0] r_mem [NREGS];

    // Storage: synchronous clear, single write per cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < NREGS; k++) begin
                r_mem[k] <= 8'h00;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port is combinational so a read command can stage data in one cycle
    always_comb begin
        o_rdata = r_mem[i_raddr];
    end

    generate
        for (genvar g = 0; g < NREGS; g++) begin : g_flat
            assign o_regs[8*g +: 8] = r_mem[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cmd_ctrl
//  Description : System-clock command sequencer behind the SPI slave. Parses
//                WR / RD / NOP / CLR_ERR frames, owns the register file and
//                stages read data for the SPI transmit path.
//                Optional open-frame timeout: define SPI_CMD_TIMEOUT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int NREGS       = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  wire logic                 i_clk,
    input  wire logic                 i_sys_rst,
    input  wire logic                 i_cs,
    input  wire logic [7:0]           i_rx_byte,
    input  wire logic                 i_rx_valid,
    output logic      [7:0]           o_tx_byte,
    output logic                      o_tx_rdy,
    output logic      [8*NREGS-1:0]   o_regs,
    output logic                      o_wr_strobe,
    output logic      [7:0]           o_wr_addr,
    output logic                      o_busy,
    output logic                      o_err
);

    localparam int         c_aw      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [8:0] c_nregs9  = 9'(NREGS);

    // ------------------------------------------------------------------
    // Chip-select synchroniser and rising-edge (end of frame) detect.
    // Flops reset high so a deasserted bus never produces a false edge.
    // ------------------------------------------------------------------
    logic r_cs_meta, r_cs_sync, r_cs_last;
    logic w_cs_rise;

    // Two-flop synchroniser plus one delay stage for edge detection
    always_ff @(posedge i_clk) begin
        if (i_sys_rst) begin
            r_cs_meta <= 1'b1;
            r_cs_sync <= 1'b1;
            r_cs_last <= 1'b1;
        end else begin
            r_cs_meta <= i_cs;
            r_cs_sync <= r_cs_meta;
            r_cs_last <= r_cs_sync;
        end
    end

    assign w_cs_rise = r_cs_sync & ~r_cs_last;

    // ------------------------------------------------------------------
    // Parser state and registered outputs
    // ------------------------------------------------------------------
    state_t             r_state, w_state_nx;
    logic [c_aw-1:0]    r_addr, w_addr_nx;
    logic [7:0]         r_tx_byte, w_tx_byte_nx;
    logic               r_tx_rdy, w_tx_rdy_nx;
    logic               r_wr_strobe, w_wr_strobe_nx;
    logic [7:0]         r_wr_addr, w_wr_addr_nx;
    logic               r_err, w_err_nx;
    logic               w_we;
    logic [7:0]         w_rdata;
    logic               w_in_range;
    logic               w_tmo_hit;

    // Full 8-bit byte compared against NREGS so aliasing addresses are rejected
    assign w_in_range = ({1'b0, i_rx_byte} < c_nregs9);

    // ------------------------------------------------------------------
    // Optional open-frame timeout
    // ------------------------------------------------------------------
`ifdef SPI_CMD_TIMEOUT_EN
    localparam int c_tmo_w = $clog2(TIMEOUT_CYC) + 1;

    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic               w_frame_open;

    assign w_frame_open = (r_state == ST_WADDR) || (r_state == ST_WDATA) ||
                          (r_state == ST_RADDR);
    assign w_tmo_hit    = w_frame_open && (r_tmo_cnt == c_tmo_w'(TIMEOUT_CYC - 1));

    // Idle-cycle counter: restarts on every byte and whenever the parser goes idle
    always_ff @(posedge i_clk) begin
        if (i_sys_rst || i_rx_valid || (w_state_nx == ST_IDLE)) begin
            r_tmo_cnt <= '0;
        end else if (w_frame_open) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end
`else
    logic [31:0] w_unused_tmo;

    assign w_unused_tmo = TIMEOUT_CYC;
    assign w_tmo_hit    = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_sys_rst) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_tx_byte   <= 8'h00;
            r_tx_rdy    <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 8'h00;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_addr      <= w_addr_nx;
            r_tx_byte   <= w_tx_byte_nx;
            r_tx_rdy    <= w_tx_rdy_nx;
            r_wr_strobe <= w_wr_strobe_nx;
            r_wr_addr   <= w_wr_addr_nx;
            r_err       <= w_err_nx;
        end
    end

    // Next-state and output decode; frame abort has priority over a byte
    always_comb begin
        w_state_nx     = r_state;
        w_addr_nx      = r_addr;
        w_tx_byte_nx   = r_tx_byte;
        w_tx_rdy_nx    = 1'b0;
        w_wr_strobe_nx = 1'b0;
        w_wr_addr_nx   = r_wr_addr;
        w_err_nx       = r_err;
        w_we           = 1'b0;

        if (w_cs_rise) begin
            w_state_nx = ST_IDLE;
        end else if (i_rx_valid) begin
            unique case (r_state)
                ST_IDLE: begin
                    unique case (i_rx_byte)
                        c_op_nop:     w_state_nx = ST_IDLE;
                        c_op_clr_err: w_err_nx   = 1'b0;
                        c_op_wr:      w_state_nx = ST_WADDR;
                        c_op_rd:      w_state_nx = ST_RADDR;
                        default: begin
                            w_err_nx   = 1'b1;
                            w_state_nx = ST_ERR;
                        end
                    endcase
                end
                ST_WADDR: begin
                    if (w_in_range) begin
                        w_addr_nx  = i_rx_byte[c_aw-1:0];
                        w_state_nx = ST_WDATA;
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = ST_ERR;
                    end
                end
                ST_WDATA: begin
                    w_we           = 1'b1;
                    w_wr_strobe_nx = 1'b1;
                    w_wr_addr_nx   = 8'(r_addr);
                    w_state_nx     = ST_IDLE;
                end
                ST_RADDR: begin
                    w_tx_rdy_nx = 1'b1;
                    if (w_in_range) begin
                        w_tx_byte_nx = w_rdata;
                        w_state_nx   = ST_IDLE;
                    end else begin
                        w_tx_byte_nx = c_tx_err_byte;
                        w_err_nx     = 1'b1;
                        w_state_nx   = ST_ERR;
                    end
                end
                ST_ERR: begin
                    w_state_nx = ST_ERR;
                end
                default: begin
                    w_state_nx = ST_IDLE;
                end
            endcase
        end else if (w_tmo_hit) begin
            w_err_nx   = 1'b1;
            w_state_nx = ST_IDLE;
        end
    end

    spi_cmd_regfile #(
        .NREGS   (NREGS),
        .ADDR_W  (c_aw)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_rst   (i_sys_rst),
        .i_we    (w_we),
        .i_waddr (r_addr),
        .i_wdata (i_rx_byte),
        .i_raddr (i_rx_byte[c_aw-1:0]),
        .o_rdata (w_rdata),
        .o_regs  (o_regs)
    );

    assign o_tx_byte   = r_tx_byte;
    assign o_tx_rdy    = r_tx_rdy;
    assign o_wr_strobe = r_wr_strobe;
    assign o_wr_addr   = r_wr_addr;
    assign o_busy      = (r_state != ST_IDLE);
    assign o_err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_cmd_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_cmd_ctrl
//  Description : Directed self-checking bench for spi_cmd_ctrl (NREGS = 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic [7:0]  tx_byte;
    logic        tx_rdy;
    logic [63:0] regs;
    logic        wr_strobe;
    logic [7:0]  wr_addr;
    logic        busy;
    logic        err;

    int vectors     = 0;
    int miscompares = 0;

    spi_cmd_ctrl #(
        .NREGS       (8),
        .TIMEOUT_CYC (16)
    ) dut (
        .i_clk       (clk),
        .i_sys_rst   (rst),
        .i_cs        (cs),
        .i_rx_byte   (rx_byte),
        .i_rx_valid  (rx_valid),
        .o_tx_byte   (tx_byte),
        .o_tx_rdy    (tx_rdy),
        .o_regs      (regs),
        .o_wr_strobe (wr_strobe),
        .o_wr_addr   (wr_addr),
        .o_busy      (busy),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Byte strobe driven at a falling edge; returns at the next falling edge,
    // where the registered response to the byte is visible.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk);
        cs = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk);
        cs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst      = 1'b1;
        cs       = 1'b1;
        rx_byte  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Reset / idle state
        chk("rst_tx_byte",   tx_byte,   8'h00);
        chk("rst_tx_rdy",    tx_rdy,    1'b0);
        chk("rst_wr_strobe", wr_strobe, 1'b0);
        chk("rst_wr_addr",   wr_addr,   8'h00);
        chk("rst_busy",      busy,      1'b0);
        chk("rst_err",       err,       1'b0);
        chk("rst_regs",      regs,      64'h0);

        // Write reg[3] = A5
        cs_low();
        send(8'h01);
        chk("wr_busy",       busy,      1'b1);
        send(8'h03);
        send(8'hA5);
        chk("wr_strobe",     wr_strobe, 1'b1);
        chk("wr_addr",       wr_addr,   8'h03);
        chk("wr_regs",       regs,      64'h00000000_A5000000);
        @(negedge clk);
        chk("wr_strobe_end", wr_strobe, 1'b0);
        chk("wr_idle",       busy,      1'b0);
        cs_high();

        // Read reg[3]
        cs_low();
        send(8'h02);
        send(8'h03);
        chk("rd_tx_rdy",     tx_rdy,    1'b1);
        chk("rd_tx_byte",    tx_byte,   8'hA5);
        @(negedge clk);
        chk("rd_tx_rdy_end", tx_rdy,    1'b0);
        chk("rd_err",        err,       1'b0);
        cs_high();

        // Illegal opcode: sticky error, following bytes ignored
        cs_low();
        send(8'h7F);
        chk("ill_err",       err,       1'b1);
        send(8'h01);
        send(8'h00);
        send(8'h55);
        chk("ill_no_strobe", wr_strobe, 1'b0);
        chk("ill_busy",      busy,      1'b1);
        chk("ill_regs",      regs,      64'h00000000_A5000000);
        cs_high();
        chk("ill_abort",     busy,      1'b0);
        chk("ill_sticky",    err,       1'b1);
        cs_low();
        send(8'h0E);
        chk("clr_err",       err,       1'b0);
        cs_high();

        // Partial frame aborted by CS, then a complete write
        cs_low();
        send(8'h01);
        send(8'h02);
        cs_high();
        chk("abort_busy",    busy,      1'b0);
        chk("abort_regs",    regs,      64'h00000000_A5000000);
        chk("abort_err",     err,       1'b0);
        cs_low();
        send(8'h01);
        send(8'h02);
        send(8'h11);
        chk("abort_wr_regs", regs,      64'h00000000_A5110000);
        chk("abort_wr_addr", wr_addr,   8'h02);
        cs_high();

        // Out-of-range read (address == NREGS)
        cs_low();
        send(8'h02);
        send(8'h08);
        chk("oor_tx_byte",   tx_byte,   8'hFF);
        chk("oor_tx_rdy",    tx_rdy,    1'b1);
        chk("oor_err",       err,       1'b1);
        cs_high();

        // Highest legal address, two commands in one frame
        cs_low();
        send(8'h0E);
        chk("top_clr",       err,       1'b0);
        send(8'h01);
        send(8'h07);
        send(8'h3C);
        chk("top_wr_addr",   wr_addr,   8'h07);
        chk("top_regs",      regs,      64'h3C000000_A5110000);
        send(8'h02);
        send(8'h02);
        chk("top_rd",        tx_byte,   8'h11);
        cs_high();

        // Out-of-range write address
        cs_low();
        send(8'h01);
        send(8'h20);
        chk("wadr_err",      err,       1'b1);
        chk("wadr_busy",     busy,      1'b1);
        cs_high();
        chk("wadr_regs",     regs,      64'h3C000000_A5110000);

`ifdef SPI_CMD_TIMEOUT_EN
        cs_low();
        send(8'h0E);
        send(8'h01);
        repeat (16) @(negedge clk);
        chk("tmo_busy",      busy,      1'b0);
        chk("tmo_err",       err,       1'b1);
        cs_high();
`endif

        // Reset mid-frame
        cs_low();
        send(8'h01);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_busy",     busy,      1'b0);
        chk("mrst_regs",     regs,      64'h0);
        chk("mrst_err",      err,       1'b0);
        cs_high();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
